dram_byte_pattern_tester: RTL
=============================

Name: dram_byte_pattern_tester

Overview:
- sys_clk_75MHz-domain traffic source and sink for the DDR3 byte-wide FIFO ports.
- Pushes a deterministic LFSR byte stream into the 8-bit write side of the write FIFO.
- Pops the returned stream from the 8-bit read side of the read FIFO and compares it byte by byte against a regenerated copy of the same stream.
- Reports pass/fail, error count, first-error details and timeout/abort status for board-level DRAM bring-up.

Parameters:
TOTAL_BYTES, 4096, bytes per test run; must be a multiple of 16, max 65536.
TIMEOUT_CYCLES, 1_000_000, max sys_clk cycles without a returned byte before the run is declared timed out.
DEFAULT_SEED, 16'hACE1, seed substituted when I_seed == 0.

Ports:
sys_clk_75MHz  in  1  clock
I_rst_n  in  1  async active-low reset
I_calib_complete  in  1  DDR calibration done; comes from the mem_intf_clk domain
I_start  in  1  one-cycle start pulse
I_seed  in  16  LFSR seed, sampled on an accepted start
O_wr_fifo_data  out  8  byte to write FIFO Data
O_wr_fifo_en  out  1  write FIFO WrEn
I_wr_fifo_full  in  1  write FIFO Full
O_rd_fifo_en  out  1  read FIFO RdEn
I_rd_fifo_data  in  8  read FIFO Q
I_rd_fifo_empty  in  1  read FIFO Empty
O_busy  out  1  run in progress
O_done  out  1  sticky run-finished flag
O_pass  out  1  run finished clean
O_timeout  out  1  run ended by timeout
O_abort  out  1  run ended by loss of calibration
O_err_count  out  16  saturating mismatch count
O_first_err_idx  out  16  byte index of first mismatch
O_first_err_exp  out  8  expected byte at first mismatch
O_first_err_got  out  8  received byte at first mismatch

Behaviour:
- Reset: I_rst_n is asynchronous, active-low; the block is clocked on sys_clk_75MHz. On reset every output is 0 and the state is IDLE.
- Calibration sync: I_calib_complete passes through a 2-flop synchronizer (calib_s) before any use.
- LFSR: 16-bit, next = {l[14:0], l[15]^l[13]^l[12]^l[10]}. Emitted byte = l[7:0], taken before the step. Separate write and check LFSRs, both loaded with the same seed.
- State IDLE:
  - I_start & calib_s -> RUN. Load both LFSRs with (I_seed ? I_seed : DEFAULT_SEED).
  - Clear wr_cnt, rd_cnt, chk_cnt, the timeout counter, O_err_count, O_first_err_*, O_done, O_pass, O_timeout and O_abort.
  - I_start while !calib_s is ignored.
- State RUN, write side:
  - O_wr_fifo_en = RUN & wr_cnt<TOTAL_BYTES & !I_wr_fifo_full (combinational).
  - O_wr_fifo_data = write LFSR[7:0].
  - On en: wr_cnt++ and the write LFSR steps.
  - No write is ever issued while Full.
- State RUN, read side:
  - O_rd_fifo_en = RUN & rd_cnt<TOTAL_BYTES & !I_rd_fifo_empty (combinational); rd_cnt++ on en.
  - Q is valid exactly 1 cycle after RdEn; rd_vld is a 1-cycle delayed copy of en.
  - On rd_vld: compare I_rd_fifo_data with check LFSR[7:0], step the check LFSR, chk_cnt++.
  - On mismatch: O_err_count++ (saturates at 16'hFFFF). If this is the first mismatch, latch idx = chk_cnt, exp and got.
- Write and read proceed concurrently; simultaneous WrEn and RdEn are legal.
- Timeout counter: cleared on rd_vld, otherwise increments while RUN.
- RUN exits, priority order:
  1. !calib_s -> DONE with O_abort=1.
  2. Timeout counter == TIMEOUT_CYCLES-1 -> DONE with O_timeout=1.
  3. chk_cnt == TOTAL_BYTES (last compare done) -> DONE.
- Entering DONE: O_done=1; O_pass = (err_count==0) & !timeout & !abort. A compare in flight in the same cycle as abort/timeout is discarded.
- State DONE: results hold. I_start & calib_s behaves as in IDLE (new run). I_start while !calib_s is ignored.
- O_busy = (state==RUN).
- I_start while RUN is ignored.
- Reset mid-run returns to IDLE immediately with all outputs 0. Bytes already in the FIFOs are not drained; the FIFOs are reset by calibration loss.
- Byte counters are 17 bits wide so that TOTAL_BYTES=65536 is representable.

Test Plan:
- Seed 16'h0001, TOTAL_BYTES=16, ideal loopback model (write FIFO -> read FIFO, 20-cycle delay):
  - First 8 bytes written are 01 02 04 08 10 20 40 80.
  - O_done=1, O_pass=1, O_err_count=0, exactly 16 WrEn and 16 RdEn pulses.
- Loopback corrupts byte index 5 (XOR 8'hFF), seed 1:
  - O_err_count=1, O_first_err_idx=5, exp=8'h20, got=8'hDF, O_pass=0.
- Full held high for 100 cycles mid-run and Empty toggled randomly:
  - No WrEn while Full, no RdEn while Empty, no lost or duplicated bytes, O_pass=1.
- Loopback drops all data, TIMEOUT_CYCLES=1000:
  - O_done=1, O_timeout=1, O_pass=0 at 1000 cycles after the last rd_vld, or after RUN entry if no byte ever returns.
- Calibration deasserted at byte 300 with TOTAL_BYTES=4096:
  - O_abort=1 within 3 cycles, O_busy=0.
  - I_start while calib low is ignored.
  - After calib returns, I_start begins a fresh run and all results clear.
- I_rst_n asserted mid-run:
  - All outputs 0 asynchronously; FIFO enables deassert immediately.
  - Second I_start pulse during RUN is ignored.

Source files
------------

// File: rtl/dram_byte_pattern_tester_if.sv
// Byte-wide FIFO port bundle between the pattern tester and the DDR3 FIFOs.
//   O_wr_fifo_data  : byte to write FIFO Data
//   O_wr_fifo_en    : write FIFO WrEn
//   I_wr_fifo_full  : write FIFO Full
//   O_rd_fifo_en    : read FIFO RdEn
//   I_rd_fifo_data  : read FIFO Q (valid one cycle after RdEn)
//   I_rd_fifo_empty : read FIFO Empty
// master = tester side, slave = FIFO side.
interface dram_byte_pattern_tester_if;
    logic [7:0] O_wr_fifo_data;
    logic       O_wr_fifo_en;
    logic       I_wr_fifo_full;
    logic       O_rd_fifo_en;
    logic [7:0] I_rd_fifo_data;
    logic       I_rd_fifo_empty;

    modport master (
        output O_wr_fifo_data,
        output O_wr_fifo_en,
        output O_rd_fifo_en,
        input  I_wr_fifo_full,
        input  I_rd_fifo_data,
        input  I_rd_fifo_empty
    );

    modport slave (
        input  O_wr_fifo_data,
        input  O_wr_fifo_en,
        input  O_rd_fifo_en,
        output I_wr_fifo_full,
        output I_rd_fifo_data,
        output I_rd_fifo_empty
    );
endinterface

// File: rtl/dram_byte_pattern_tester.sv
// DRAM bring-up traffic source/sink: streams an LFSR byte sequence into the
// write FIFO, pops the returned stream from the read FIFO and compares it
// against a regenerated copy, reporting pass/fail, error count, first-error
// details and timeout/abort status.
// Ports:
//   sys_clk_75MHz, I_rst_n (async active-low)
//   I_calib_complete : DDR calibration done (foreign domain, synchronised here)
//   I_start, I_seed  : start pulse and LFSR seed (0 selects DEFAULT_SEED)
//   fifo             : byte FIFO bundle (write side + read side)
//   O_busy, O_done, O_pass, O_timeout, O_abort : run status
//   O_err_count, O_first_err_idx/exp/got       : compare results
module dram_byte_pattern_tester #(
    parameter int unsigned TOTAL_BYTES    = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [15:0] DEFAULT_SEED   = 16'hACE1
) (
    input  logic                               sys_clk_75MHz,
    input  logic                               I_rst_n,
    input  logic                               I_calib_complete,
    input  logic                               I_start,
    input  logic [15:0]                        I_seed,
    dram_byte_pattern_tester_if.master         fifo,
    output logic                               O_busy,
    output logic                               O_done,
    output logic                               O_pass,
    output logic                               O_timeout,
    output logic                               O_abort,
    output logic [15:0]                        O_err_count,
    output logic [15:0]                        O_first_err_idx,
    output logic [7:0]                         O_first_err_exp,
    output logic [7:0]                         O_first_err_got
);

    localparam int unsigned    CNT_W     = 17;
    localparam int unsigned    TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL_BYTES);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               calib_meta;
    logic               calib_s;
    logic [15:0]        wr_lfsr;
    logic [15:0]        chk_lfsr;
    logic [CNT_W-1:0]   wr_cnt;
    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   chk_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               rd_vld;

    logic               wr_en_c;
    logic               rd_en_c;
    logic               start_c;
    logic               abort_c;
    logic               timeout_c;
    logic               finish_c;
    logic               cmp_c;
    logic               mismatch_c;
    logic [15:0]        seed_c;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Two-flop synchroniser for the calibration flag.
    always_ff @(posedge sys_clk_75MHz or negedge I_rst_n) begin
        if (!I_rst_n) begin
            calib_meta <= 1'b0;
            calib_s    <= 1'b0;
        end else begin
            calib_meta <= I_calib_complete;
            calib_s    <= calib_meta;
        end
    end

    // State register.
    always_ff @(posedge sys_clk_75MHz or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, FIFO enables and run-exit decode (exit priority: abort, timeout, finish).
    always_comb begin
        state_nxt = state;
        wr_en_c   = 1'b0;
        rd_en_c   = 1'b0;
        start_c   = 1'b0;
        abort_c   = 1'b0;
        timeout_c = 1'b0;
        finish_c  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (I_start && calib_s) begin
                    start_c   = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                wr_en_c = (wr_cnt < TOTAL_CNT) && !fifo.I_wr_fifo_full;
                rd_en_c = (rd_cnt < TOTAL_CNT) && !fifo.I_rd_fifo_empty;
                if (!calib_s) begin
                    abort_c   = 1'b1;
                    state_nxt = S_DONE;
                end else if (to_cnt == TO_LAST) begin
                    timeout_c = 1'b1;
                    state_nxt = S_DONE;
                end else if (chk_cnt == TOTAL_CNT) begin
                    finish_c  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign seed_c     = (I_seed != 16'd0) ? I_seed : DEFAULT_SEED;
    // A returning byte in the same cycle as abort/timeout is dropped.
    assign cmp_c      = rd_vld && (state == S_RUN) && !abort_c && !timeout_c;
    assign mismatch_c = cmp_c && (fifo.I_rd_fifo_data != chk_lfsr[7:0]);

    assign fifo.O_wr_fifo_en   = wr_en_c;
    assign fifo.O_rd_fifo_en   = rd_en_c;
    assign fifo.O_wr_fifo_data = wr_lfsr[7:0];

    // Stream generation, compare datapath and result registers.
    always_ff @(posedge sys_clk_75MHz or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wr_lfsr         <= 16'd0;
            chk_lfsr        <= 16'd0;
            wr_cnt          <= '0;
            rd_cnt          <= '0;
            chk_cnt         <= '0;
            to_cnt          <= '0;
            rd_vld          <= 1'b0;
            O_busy          <= 1'b0;
            O_done          <= 1'b0;
            O_pass          <= 1'b0;
            O_timeout       <= 1'b0;
            O_abort         <= 1'b0;
            O_err_count     <= 16'd0;
            O_first_err_idx <= 16'd0;
            O_first_err_exp <= 8'd0;
            O_first_err_got <= 8'd0;
        end else begin
            rd_vld <= rd_en_c;
            O_busy <= (state_nxt == S_RUN);
            if (start_c) begin
                wr_lfsr         <= seed_c;
                chk_lfsr        <= seed_c;
                wr_cnt          <= '0;
                rd_cnt          <= '0;
                chk_cnt         <= '0;
                to_cnt          <= '0;
                O_done          <= 1'b0;
                O_pass          <= 1'b0;
                O_timeout       <= 1'b0;
                O_abort         <= 1'b0;
                O_err_count     <= 16'd0;
                O_first_err_idx <= 16'd0;
                O_first_err_exp <= 8'd0;
                O_first_err_got <= 8'd0;
            end else if (state == S_RUN) begin
                if (wr_en_c) begin
                    wr_cnt  <= wr_cnt + CNT_W'(1);
                    wr_lfsr <= lfsr_step(wr_lfsr);
                end
                if (rd_en_c) begin
                    rd_cnt <= rd_cnt + CNT_W'(1);
                end
                if (cmp_c) begin
                    chk_lfsr <= lfsr_step(chk_lfsr);
                    chk_cnt  <= chk_cnt + CNT_W'(1);
                    to_cnt   <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
                if (mismatch_c) begin
                    if (O_err_count != 16'hFFFF) begin
                        O_err_count <= O_err_count + 16'd1;
                    end
                    // Error count never wraps to zero, so zero marks "no error yet".
                    if (O_err_count == 16'd0) begin
                        O_first_err_idx <= 16'(chk_cnt);
                        O_first_err_exp <= chk_lfsr[7:0];
                        O_first_err_got <= fifo.I_rd_fifo_data;
                    end
                end
                if (abort_c || timeout_c || finish_c) begin
                    O_done    <= 1'b1;
                    O_abort   <= abort_c;
                    O_timeout <= timeout_c;
                    O_pass    <= finish_c && (O_err_count == 16'd0);
                end
            end
        end
    end

endmodule
